// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_arbiter : round-robin byte arbiter (optional packet lock) for one uart_tx
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LOCK_EN = 1,
  parameter int BUSY_TO = 4,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 locked,
  output logic                 err_no_busy
);

  localparam int             TW       = $clog2(BUSY_TO) + 1;
  localparam logic [TW-1:0]  TO_LAST  = TW'(BUSY_TO - 1);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] next_ptr;
  logic           win_ok;
  logic           hs;
  logic           next_locked;
  logic [TW-1:0]  timer;
  logic [7:0]     data_arr [NUM_REQ];
  int             idx;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[8*g +: 8];
    end
  endgenerate

  // Descending scan so the requester closest to rr_ptr is the last to overwrite.
  always_comb begin
    win    = grant_id;
    win_ok = 1'b0;
    idx    = 0;
    if (locked) begin
      win_ok = req_valid[grant_id];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (req_valid[idx[IDW-1:0]]) begin
          win    = idx[IDW-1:0];
          win_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    hs        = 1'b0;
    if (!rst && state == S_IDLE && win_ok && !tx_busy) begin
      req_ready[win] = 1'b1;
      hs             = 1'b1;
    end
  end

  assign next_locked = (LOCK_EN != 0) && !req_last[win];
  assign next_ptr    = (win == LAST_IDX) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      locked      <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      err_no_busy <= 1'b0;
      timer       <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs) begin
            tx_data  <= data_arr[win];
            tx_start <= 1'b1;
            grant_id <= win;
            locked   <= next_locked;
            if (!next_locked) rr_ptr <= next_ptr;
            state    <= S_START;
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (tx_busy) begin
            state <= S_WAIT_LO;
          end else if (timer == TO_LAST) begin
            err_no_busy <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_LO: begin
          // Frame length is owned by the uart baud setting, so no timeout here.
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Bench for uart_tx_arbiter: queued requesters, uart busy model, scoreboard of issued bytes.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int FRAME = 10;

  typedef struct {logic [7:0] d; logic l; int gap;} ent_t;
  typedef struct {int id; logic [7:0] d; logic lk;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic           sel       = 1'b0;
  logic           busy_en   = 1'b1;
  int             busy_cnt  = 0;
  logic           tx_busy;

  logic [N-1:0] valid_l, valid_n, ready_l, ready_n, req_ready;
  logic         start_l, start_n, tx_start;
  logic [7:0]   data_l, data_n, tx_data;
  logic [1:0]   gid_l, gid_n, gid;
  logic         lk_l, lk_n, lk, err_l, err_n, err;

  assign valid_l   = sel ? '0 : req_valid;
  assign valid_n   = sel ? req_valid : '0;
  assign req_ready = sel ? ready_n : ready_l;
  assign tx_start  = sel ? start_n : start_l;
  assign tx_data   = sel ? data_n : data_l;
  assign gid       = sel ? gid_n : gid_l;
  assign lk        = sel ? lk_n : lk_l;
  assign err       = sel ? err_n : err_l;
  assign tx_busy   = (busy_cnt != 0);

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_EN(1), .BUSY_TO(4)) dut_l (
    .clk(clk), .rst(rst), .req_valid(valid_l), .req_data(req_data), .req_last(req_last),
    .req_ready(ready_l), .tx_start(start_l), .tx_data(data_l), .tx_busy(tx_busy),
    .grant_id(gid_l), .locked(lk_l), .err_no_busy(err_l));

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_EN(0), .BUSY_TO(4)) dut_n (
    .clk(clk), .rst(rst), .req_valid(valid_n), .req_data(req_data), .req_last(req_last),
    .req_ready(ready_n), .tx_start(start_n), .tx_data(data_n), .tx_busy(tx_busy),
    .grant_id(gid_n), .locked(lk_n), .err_no_busy(err_n));

  // uart_tx stand-in: busy rises the cycle after tx_start and lasts FRAME cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start && busy_en) busy_cnt <= FRAME;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  int   checks   = 0;
  int   failures = 0;
  exp_t expq[$];
  ent_t rq[N][$];
  int   gapc[N];
  logic [N-1:0] pend = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(int id, logic [7:0] d, logic l, int gap);
    ent_t e;
    e.d = d; e.l = l; e.gap = gap;
    rq[id].push_back(e);
  endtask

  task automatic expect_tx(int id, logic [7:0] d, logic lkv);
    exp_t e;
    e.id = id; e.d = d; e.lk = lkv;
    expq.push_back(e);
  endtask

  function automatic bit pending_any();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  // Requester driver: head of each queue is held valid until its handshake.
  initial begin
    for (int i = 0; i < N; i++) gapc[i] = -1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (pend[i] && rq[i].size() != 0) begin
          rq[i].delete(0);
          gapc[i] = -1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() != 0) begin
          if (gapc[i] < 0) gapc[i] = rq[i][0].gap;
          if (gapc[i] > 0) begin
            gapc[i]--;
            req_valid[i] = 1'b0;
          end else begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = rq[i][0].d;
            req_last[i]        = rq[i][0].l;
          end
        end else begin
          req_valid[i] = 1'b0;
          gapc[i]      = -1;
        end
      end
      #1 pend = rst ? '0 : (req_valid & req_ready);
    end
  end

  // Monitor: every tx_start must match the next expected byte.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (tx_start) begin
        check("start_vs_busy", tx_busy, 0);
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_start: got data %0h id %0d expected none", tx_data, gid);
        end else begin
          e = expq.pop_front();
          check("grant_id", gid, e.id);
          check("tx_data", tx_data, e.d);
          check("locked", lk, e.lk);
        end
      end
      if (req_ready != '0) check("ready_onehot", $countones(req_ready), 1);
    end
  end

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || pending_any()) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", expq.size());
      expq.delete();
      for (int i = 0; i < N; i++) rq[i].delete();
    end
    repeat (16) @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #2;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant", gid, 0);
    check("rst_locked", lk, 0);
    check("rst_err", err, 0);
    check("rst_ready", req_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #2;

    // 1: single byte from req0
    push(0, 8'hA5, 1'b1, 0); expect_tx(0, 8'hA5, 1'b0);
    @(negedge clk); #2;
    check("t1_ready0", req_ready, 4'b0001);
    drain();
    check("t1_grant", gid, 0);
    check("t1_locked", lk, 0);
    check("t1_rr_ptr", dut_l.rr_ptr, 1);

    // 2: all four valid -> 0,1,2,3,0
    do_reset();
    push(0, 8'h10, 1'b1, 0); push(1, 8'h11, 1'b1, 0); push(2, 8'h12, 1'b1, 0);
    push(3, 8'h13, 1'b1, 0); push(0, 8'h14, 1'b1, 0);
    expect_tx(0, 8'h10, 0); expect_tx(1, 8'h11, 0); expect_tx(2, 8'h12, 0);
    expect_tx(3, 8'h13, 0); expect_tx(0, 8'h14, 0);
    drain();

    // 3: locked packet from req1 with a long valid gap; req2 must wait
    do_reset();
    push(1, 8'h21, 1'b0, 0); push(1, 8'h22, 1'b0, 20); push(1, 8'h23, 1'b1, 0);
    push(2, 8'h31, 1'b1, 0); push(2, 8'h32, 1'b1, 0);
    expect_tx(1, 8'h21, 1); expect_tx(1, 8'h22, 1); expect_tx(1, 8'h23, 0);
    expect_tx(2, 8'h31, 0); expect_tx(2, 8'h32, 0);
    drain();
    check("t3_unlocked", lk, 0);

    // 4: same requesters without lock -> interleaved
    sel = 1'b1;
    do_reset();
    push(1, 8'h21, 1'b0, 0); push(1, 8'h22, 1'b0, 0); push(1, 8'h23, 1'b1, 0);
    push(2, 8'h31, 1'b1, 0); push(2, 8'h32, 1'b1, 0);
    expect_tx(1, 8'h21, 0); expect_tx(2, 8'h31, 0); expect_tx(1, 8'h22, 0);
    expect_tx(2, 8'h32, 0); expect_tx(1, 8'h23, 0);
    drain();
    sel = 1'b0;

    // 5: busy never rises -> sticky error after 4 wait cycles
    do_reset();
    busy_en = 1'b0;
    push(0, 8'h51, 1'b1, 0); expect_tx(0, 8'h51, 0);
    n = 0;
    while (!tx_start && n < 20) begin @(negedge clk); #2; n++; end
    check("t5_start_seen", tx_start, 1);
    repeat (4) @(negedge clk);
    #2 check("t5_err_not_yet", err, 0);
    @(negedge clk);
    #2 check("t5_err_set", err, 1);
    push(2, 8'h52, 1'b1, 0); expect_tx(2, 8'h52, 0);
    drain();
    check("t5_err_held", err, 1);
    busy_en = 1'b1;
    push(1, 8'h53, 1'b1, 0); expect_tx(1, 8'h53, 0);
    drain();
    check("t5_err_sticky", err, 1);

    // 6: reset while req3 is locked and frame in flight
    push(3, 8'h61, 1'b0, 0); push(3, 8'h62, 1'b1, 0);
    expect_tx(3, 8'h61, 1);
    n = 0;
    while (busy_cnt == 0 && n < 40) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #2 check("t6_locked_pre", lk, 1);
    rst = 1'b1;
    #1;
    check("t6_tx_start", tx_start, 0);
    check("t6_tx_data", tx_data, 0);
    check("t6_grant", gid, 0);
    check("t6_locked", lk, 0);
    check("t6_err", err, 0);
    check("t6_ready", req_ready, 0);
    check("t6_rr_ptr", dut_l.rr_ptr, 0);
    push(0, 8'h70, 1'b1, 0);
    expect_tx(0, 8'h70, 0); expect_tx(3, 8'h62, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #2;
    check("t6_req0_wins", req_ready, 4'b0001);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
